dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: port C (processor core load/store path) and port D (debug/loader access used for memory preload and inspection).
- Sits between the core/debug logic and dmem; drives dmem's write-enable, address and write-data inputs, and receives dmem's combinational read data.
- Fixed priority to C, with a bounded-starvation guarantee for D.
- Two-state FSM; every access takes a 2-cycle slot.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundles the core, debug and dmem signals of the data-memory arbiter.
// No logic; the slave view is the arbiter, the master view is the requesters/dmem side.
// Flow control is a req/gnt handshake; requesters hold their request until granted.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between core (C, priority) and debug (D, bounded starvation).
// Latency: req sampled in N -> gnt in N+1 -> rvalid/rdata in N+2; one access per 2 cycles.
// Backpressure: losing/waiting requester simply holds req; dropping req before gnt withdraws it.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic          sel_q;              // 0: core owns the slot, 1: debug
    logic [3:0]    starve_q, starve_d;
    logic          grant_c, grant_d;

    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          c_gnt_q, d_gnt_q;
    logic          c_rvalid_q, d_rvalid_q;
    logic [DW-1:0] c_rdata_q, d_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (grant_c || grant_d)
                sel_q <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        grant_c  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.c_req && (!bus.d_req || starve_q != MAX_CNT))
                    grant_c = 1'b1;
                else if (bus.d_req)
                    grant_d = 1'b1;
                // Count only core wins that made a waiting debug request lose
                if (grant_c && bus.d_req)
                    starve_d = (starve_q == MAX_CNT) ? starve_q : starve_q + 4'd1;
                else
                    starve_d = '0;
                if (grant_c || grant_d)
                    state_d = ACCESS;
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else if (state_q == IDLE) begin
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_gnt_q    <= grant_c;
            d_gnt_q    <= grant_d;
            if (grant_d) begin
                m_we_q    <= bus.d_we;
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_wdata;
            end else if (grant_c) begin
                m_we_q    <= bus.c_we;
                m_addr_q  <= bus.c_addr;
                m_wdata_q <= bus.c_wdata;
            end
        end else begin
            c_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
            m_we_q  <= 1'b0;
            if (!m_we_q) begin
                if (sel_q) begin
                    d_rdata_q  <= bus.m_rdata;
                    d_rvalid_q <= 1'b1;
                end else begin
                    c_rdata_q  <= bus.m_rdata;
                    c_rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.c_gnt    = c_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed dmem model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign bus.m_rdata = mem[bus.m_addr[9:2]];
    always @(posedge clk)
        if (bus.m_we)
            mem[bus.m_addr[9:2]] <= bus.m_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt/rvalid/m_we"},
              {59'd0, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.m_we}, 64'd0);
        check({tag, " m_addr"},  {32'd0, bus.m_addr},  64'd0);
        check({tag, " m_wdata"}, {32'd0, bus.m_wdata}, 64'd0);
        check({tag, " c_rdata"}, {32'd0, bus.c_rdata}, 64'd0);
        check({tag, " d_rdata"}, {32'd0, bus.d_rdata}, 64'd0);
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEAD_BEEF;   // 0x10
        mem[8]  = 32'hCAFE_0008;   // 0x20
        mem[12] = 32'h3333_3030;   // 0x30
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        step();
        check_all_zero("reset");
        reset = 1'b1;

        // Core write then read of 0x64
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h64; bus.c_wdata = 32'h7;
        step();
        check("t1 wr c_gnt", {63'd0, bus.c_gnt}, 64'd1);
        check("t1 wr m_we", {63'd0, bus.m_we}, 64'd1);
        check("t1 wr m_addr", {32'd0, bus.m_addr}, 64'h64);
        check("t1 wr m_wdata", {32'd0, bus.m_wdata}, 64'h7);
        bus.c_req = 0;
        step();
        check("t1 wr gnt/rvalid/we clear", {61'd0, bus.c_gnt, bus.c_rvalid, bus.m_we}, 64'd0);
        check("t1 mem committed", {32'd0, mem[25]}, 64'h7);
        bus.c_req = 1; bus.c_we = 0;
        step();
        check("t1 rd c_gnt", {63'd0, bus.c_gnt}, 64'd1);
        check("t1 rd c_rvalid early", {63'd0, bus.c_rvalid}, 64'd0);
        bus.c_req = 0;
        step();
        check("t1 rd c_rvalid", {63'd0, bus.c_rvalid}, 64'd1);
        check("t1 rd c_rdata", {32'd0, bus.c_rdata}, 64'h7);

        // Debug-only read of preloaded 0x10
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
        step();
        check("t2 gnt c/d", {62'd0, bus.c_gnt, bus.d_gnt}, 64'b01);
        check("t2 c_rvalid cleared", {63'd0, bus.c_rvalid}, 64'd0);
        bus.d_req = 0;
        step();
        check("t2 rvalid c/d", {62'd0, bus.c_rvalid, bus.d_rvalid}, 64'b01);
        check("t2 d_rdata", {32'd0, bus.d_rdata}, 64'hDEAD_BEEF);
        check("t2 c_rdata held", {32'd0, bus.c_rdata}, 64'h7);

        // Continuous contention: expect C,C,C,C,D repeating, 2 cycles apart
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h64;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
        prev_g = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i % 2 == 0) begin
                exp_g = ((i / 2) % 5 == 4) ? 2'b01 : 2'b10;
                check($sformatf("t3 slot%0d gnt c/d", i / 2), {62'd0, bus.c_gnt, bus.d_gnt}, {62'd0, exp_g});
                prev_g = exp_g;
            end else begin
                check($sformatf("t3 gap%0d gnt c/d", i / 2), {62'd0, bus.c_gnt, bus.d_gnt}, 64'd0);
                check($sformatf("t3 gap%0d rvalid c/d", i / 2), {62'd0, bus.c_rvalid, bus.d_rvalid}, {62'd0, prev_g});
            end
        end
        bus.c_req = 0; bus.d_req = 0;
        step();

        // Reset again, then simultaneous first request
        reset = 1'b0;
        #1 check_all_zero("t4 reset");
        step();
        reset = 1'b1;
        bus.c_req = 1; bus.d_req = 1;
        step();
        check("t4 first gnt c/d", {62'd0, bus.c_gnt, bus.d_gnt}, 64'b10);
        bus.c_req = 0;
        step();
        check("t4 gap gnt c/d", {62'd0, bus.c_gnt, bus.d_gnt}, 64'd0);
        step();
        check("t4 d sole gnt c/d", {62'd0, bus.c_gnt, bus.d_gnt}, 64'b01);
        bus.d_req = 0;
        step();
        check("t4 d_rvalid", {62'd0, bus.c_rvalid, bus.d_rvalid}, 64'b01);

        // Debug request pulsed only while core owns the ACCESS cycle
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h64;
        step();
        check("t5 c_gnt", {63'd0, bus.c_gnt}, 64'd1);
        bus.c_req = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h30; bus.d_wdata = 32'hBAD0_0BAD;
        step();
        check("t5 d_gnt after pulse", {63'd0, bus.d_gnt}, 64'd0);
        bus.d_req = 0;
        step();
        check("t5 gnt c/d idle", {62'd0, bus.c_gnt, bus.d_gnt}, 64'd0);
        check("t5 mem 0x30 untouched", {32'd0, mem[12]}, 64'h3333_3030);
        check("t5 starve_cnt", {60'd0, dut.starve_q}, 64'd0);

        // Reset asserted during a core write ACCESS
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h20; bus.c_wdata = 32'h55;
        step();
        check("t6 c_gnt", {63'd0, bus.c_gnt}, 64'd1);
        check("t6 m_we before reset", {63'd0, bus.m_we}, 64'd1);
        reset = 1'b0;
        bus.c_req = 0;
        #1 check_all_zero("t6 mid-access reset");
        step();
        check("t6 c_rvalid", {63'd0, bus.c_rvalid}, 64'd0);
        check("t6 mem 0x20 untouched", {32'd0, mem[8]}, 64'hCAFE_0008);
        reset = 1'b1;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h20;
        step();
        check("t6 rd c_gnt", {63'd0, bus.c_gnt}, 64'd1);
        bus.c_req = 0;
        step();
        check("t6 rd c_rvalid", {63'd0, bus.c_rvalid}, 64'd1);
        check("t6 rd c_rdata", {32'd0, bus.c_rdata}, 64'hCAFE_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
